// File: rtl/wave_gen_pkg.sv
// Shared encodings for the multi-channel waveform generator: modes, register offsets, LFSR seed.
package wave_gen_pkg;

    typedef enum logic [2:0] {
        ModeOff    = 3'd0,
        ModeToggle = 3'd1,
        ModePwm    = 3'd2,
        ModePrn    = 3'd3,
        ModeRect   = 3'd4,
        ModeTri    = 3'd5,
        ModeSaw    = 3'd6,
        ModeRsvd   = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        RegCtrl   = 2'd0,
        RegParam1 = 2'd1,
        RegParam2 = 2'd2,
        RegStatus = 2'd3
    } reg_e;

    localparam logic [31:0] LfsrDefaultSeed = 32'd1;

endpackage

// File: rtl/wave_chan.sv
// One waveform channel: CTRL and PARAM registers, parameter shadows and the sample generator.
module wave_chan #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [1:0]   reg_sel,
    input  logic [31:0]  wdata,
    input  logic         sync,
    output logic [W-1:0] sample,
    output logic         active,
    output logic [31:0]  rd_data
);
    import wave_gen_pkg::*;

    mode_e        mode_q, mode_d;
    logic         en_q, en_d;
    logic [31:0]  sh1_q, sh1_d, sh2_q, sh2_d;
    logic [31:0]  p1_q, p2_q;
    logic [32:0]  cnt_q, cnt_n, acc_q, acc_n;
    logic         dir_q, dir_n, tog_q, tog_n;
    logic [31:0]  lfsr_q, lfsr_n;
    logic [W-1:0] sample_q;
    logic         active_q;
    logic         restart, running, boundary;
    logic [32:0]  value, amp, prm2, sum, len;

    always_comb begin
        mode_d = mode_q;
        en_d   = en_q;
        sh1_d  = sh1_q;
        sh2_d  = sh2_q;
        if (wr_en) begin
            case (reg_sel)
                RegCtrl: begin
                    mode_d = mode_e'(wdata[2:0]);
                    en_d   = wdata[3];
                end
                RegParam1: sh1_d = wdata;
                RegParam2: sh2_d = wdata;
                default: ;
            endcase
        end
    end

    // mode_d/en_d only differ from the registers on a CTRL write that changes them
    assign restart = sync || (mode_d != mode_q) || (en_d != en_q);
    assign running = en_q && (mode_q != ModeOff) && (mode_q != ModeRsvd);

    assign amp  = {1'b0, p1_q};
    assign prm2 = {1'b0, p2_q};
    assign sum  = acc_q + prm2;
    assign len  = (p1_q == '0) ? 33'd1 : amp;

    always_comb begin
        cnt_n    = cnt_q;
        acc_n    = acc_q;
        dir_n    = dir_q;
        tog_n    = tog_q;
        lfsr_n   = lfsr_q;
        boundary = 1'b0;
        value    = '0;
        case (mode_q)
            ModeToggle: begin
                value = {32'b0, tog_q};
                if (cnt_q + 33'd1 >= len) begin
                    cnt_n    = '0;
                    tog_n    = ~tog_q;
                    boundary = 1'b1;
                end else begin
                    cnt_n = cnt_q + 33'd1;
                end
            end
            ModePwm, ModeRect: begin
                if (mode_q == ModePwm) begin
                    value = (cnt_q < amp) ? 33'd1 : 33'd0;
                end else begin
                    value = (prm2 >= 33'd2 && cnt_q < (prm2 >> 1)) ? amp : 33'd0;
                end
                // PWM period is high+low, RECT period is PARAM2; wrap marks the boundary
                if (cnt_q + 33'd1 >= ((mode_q == ModePwm) ? amp + prm2 : prm2)) begin
                    cnt_n    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_n = cnt_q + 33'd1;
                end
            end
            ModePrn: begin
                value    = {32'b0, lfsr_q[0]};
                lfsr_n   = (lfsr_q >> 1) ^ (lfsr_q[0] ? p2_q : 32'd0);
                if (lfsr_n == '0) lfsr_n = LfsrDefaultSeed;
                boundary = 1'b1;
            end
            ModeTri: begin
                value = acc_q;
                if (p2_q == '0) begin
                    acc_n    = '0;
                    dir_n    = 1'b0;
                    boundary = 1'b1;
                end else if (!dir_q) begin
                    if (sum >= amp) begin
                        acc_n = amp;
                        dir_n = 1'b1;
                    end else begin
                        acc_n = sum;
                    end
                end else if (acc_q <= prm2) begin
                    acc_n    = '0;
                    dir_n    = 1'b0;
                    boundary = 1'b1;
                end else begin
                    acc_n = acc_q - prm2;
                end
            end
            ModeSaw: begin
                value = acc_q;
                if (p2_q == '0 || sum >= amp) begin
                    acc_n    = '0;
                    boundary = 1'b1;
                end else begin
                    acc_n = sum;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= ModeOff;
            en_q     <= 1'b0;
            sh1_q    <= '0;
            sh2_q    <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            dir_q    <= 1'b0;
            tog_q    <= 1'b0;
            lfsr_q   <= '0;
            sample_q <= '0;
            active_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            en_q     <= en_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            active_q <= running;
            if (restart || !running) begin
                p1_q     <= sh1_d;
                p2_q     <= sh2_d;
                cnt_q    <= '0;
                acc_q    <= '0;
                dir_q    <= 1'b0;
                tog_q    <= 1'b0;
                lfsr_q   <= !restart ? 32'd0 : (sh1_d == '0) ? LfsrDefaultSeed : sh1_d;
                sample_q <= '0;
            end else begin
                cnt_q    <= cnt_n;
                acc_q    <= acc_n;
                dir_q    <= dir_n;
                tog_q    <= tog_n;
                lfsr_q   <= lfsr_n;
                sample_q <= value[W-1:0];
                if (boundary) begin
                    p1_q <= sh1_d;
                    p2_q <= sh2_d;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            RegCtrl:   rd_data = {28'b0, en_q, mode_q};
            RegParam1: rd_data = sh1_q;
            RegParam2: rd_data = sh2_q;
            default:   rd_data = 32'(sample_q);
        endcase
    end

    assign sample = sample_q;
    assign active = active_q;

endmodule

// File: rtl/wave_gen_mc.sv
// Multi-channel waveform generator: register decode, read-back path and NCH channel instances.
module wave_gen_mc #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [7:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rvalid,
    input  logic             sync,
    output logic [NCH*W-1:0] wave,
    output logic [NCH-1:0]   active
);
    import wave_gen_pkg::*;

    logic [3:0]  ch;
    logic [1:0]  reg_sel;
    logic [31:0] chan_rd [NCH];
    logic [31:0] rd_mux;
    logic        unused_addr_lsb;

    assign ch              = addr[7:4];
    assign reg_sel         = addr[3:2];
    assign unused_addr_lsb = ^addr[1:0];

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        wave_chan #(
            .W(W)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_en && (ch == 4'(c))),
            .reg_sel(reg_sel),
            .wdata  (wdata),
            .sync   (sync),
            .sample (wave[c*W +: W]),
            .active (active[c]),
            .rd_data(chan_rd[c])
        );
    end

    // Channels at or above NCH never match and read back as zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch == 4'(i)) rd_mux = chan_rd[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_wave_gen_mc.sv
// Bench for wave_gen_mc: directed waveform scenarios plus random register traffic vs a cycle model.
module tb_wave_gen_mc;
    localparam int NCH = 4;
    localparam int W   = 16;
    localparam longint MASK = (64'd1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst, wr_en, rd_en, sync;
    logic [7:0]       addr;
    logic [31:0]      wdata, rdata;
    logic             rvalid;
    logic [NCH*W-1:0] wave;
    logic [NCH-1:0]   active;

    wave_gen_mc #(.NCH(NCH), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .rvalid(rvalid),
        .sync  (sync),
        .wave  (wave),
        .active(active)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: per-channel settings plus position within the current waveform
    int        m_mode [NCH];
    bit        m_en   [NCH];
    longint    m_sh1 [NCH], m_sh2 [NCH], m_p1 [NCH], m_p2 [NCH];
    longint    m_pos [NCH], m_val [NCH], m_smp [NCH];
    bit        m_down [NCH], m_tog [NCH], m_act [NCH];
    bit [31:0] m_lfsr [NCH];
    bit [31:0] m_rdata;
    bit        m_rvalid;

    function automatic bit runs(input int md, input bit e);
        return e && md >= 1 && md <= 6;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0; m_en[c] = 0; m_sh1[c] = 0; m_sh2[c] = 0; m_p1[c] = 0; m_p2[c] = 0;
            m_pos[c] = 0; m_val[c] = 0; m_smp[c] = 0; m_down[c] = 0; m_tog[c] = 0;
            m_act[c] = 0; m_lfsr[c] = 0;
        end
        m_rdata = 0;
        m_rvalid = 0;
    endtask

    // Produce this cycle's sample and advance; returns 1 at a period boundary
    function automatic bit gen_step(input int c);
        longint v;
        bit b = 0;
        v = 0;
        case (m_mode[c])
            1: begin
                v = m_tog[c];
                m_pos[c]++;
                if (m_pos[c] == ((m_p1[c] == 0) ? 1 : m_p1[c])) begin
                    m_pos[c] = 0; m_tog[c] = !m_tog[c]; b = 1;
                end
            end
            2: begin
                v = (m_pos[c] < m_p1[c]) ? 1 : 0;
                m_pos[c]++;
                if (m_pos[c] >= m_p1[c] + m_p2[c]) begin m_pos[c] = 0; b = 1; end
            end
            3: begin
                v = m_lfsr[c][0];
                if (m_lfsr[c][0]) m_lfsr[c] = (m_lfsr[c] >> 1) ^ 32'(m_p2[c]);
                else m_lfsr[c] = m_lfsr[c] >> 1;
                if (m_lfsr[c] == 0) m_lfsr[c] = 1;
                b = 1;
            end
            4: begin
                v = (m_p2[c] >= 2 && m_pos[c] < m_p2[c] / 2) ? m_p1[c] : 0;
                m_pos[c]++;
                if (m_pos[c] >= m_p2[c]) begin m_pos[c] = 0; b = 1; end
            end
            5: begin
                v = m_val[c];
                if (m_p2[c] == 0) begin
                    m_val[c] = 0; m_down[c] = 0; b = 1;
                end else if (!m_down[c]) begin
                    m_val[c] = (m_val[c] + m_p2[c] < m_p1[c]) ? m_val[c] + m_p2[c] : m_p1[c];
                    if (m_val[c] == m_p1[c]) m_down[c] = 1;
                end else begin
                    m_val[c] = (m_val[c] > m_p2[c]) ? m_val[c] - m_p2[c] : 0;
                    if (m_val[c] == 0) begin m_down[c] = 0; b = 1; end
                end
            end
            6: begin
                v = m_val[c];
                m_val[c] += m_p2[c];
                if (m_p2[c] == 0 || m_val[c] >= m_p1[c]) begin m_val[c] = 0; b = 1; end
            end
            default: ;
        endcase
        m_smp[c] = v & MASK;
        return b;
    endfunction

    task automatic model_edge(input bit we, input bit re, input logic [7:0] a,
                              input logic [31:0] d, input bit sy);
        int ch, rg, nmode;
        bit nen, rs, was, bnd;
        ch = int'(a[7:4]);
        rg = int'(a[3:2]);
        m_rvalid = re;
        if (re) begin
            if (ch >= NCH) m_rdata = 0;
            else if (rg == 0) m_rdata = {28'b0, m_en[ch], 3'(m_mode[ch])};
            else if (rg == 1) m_rdata = 32'(m_sh1[ch]);
            else if (rg == 2) m_rdata = 32'(m_sh2[ch]);
            else m_rdata = 32'(m_smp[ch]);
        end
        for (int c = 0; c < NCH; c++) begin
            nmode = m_mode[c];
            nen   = m_en[c];
            rs    = sy;
            was   = runs(m_mode[c], m_en[c]);
            if (we && ch == c) begin
                if (rg == 0) begin
                    nmode = int'(d[2:0]);
                    nen   = d[3];
                    if (nmode != m_mode[c] || nen != m_en[c]) rs = 1;
                end
                if (rg == 1) m_sh1[c] = longint'(d);
                if (rg == 2) m_sh2[c] = longint'(d);
            end
            m_act[c] = was;
            if (rs || !was) begin
                m_p1[c] = m_sh1[c]; m_p2[c] = m_sh2[c];
                m_pos[c] = 0; m_val[c] = 0; m_down[c] = 0; m_tog[c] = 0; m_smp[c] = 0;
                m_lfsr[c] = !rs ? 32'd0 : (m_sh1[c] == 0) ? 32'd1 : 32'(m_sh1[c]);
            end else begin
                bnd = gen_step(c);
                if (bnd) begin m_p1[c] = m_sh1[c]; m_p2[c] = m_sh2[c]; end
            end
            m_mode[c] = nmode;
            m_en[c]   = nen;
        end
    endtask

    function automatic logic [W-1:0] slice(input int c);
        return wave[c*W +: W];
    endfunction

    task automatic compare_all();
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("wave%0d", c), slice(c), m_smp[c]);
            check($sformatf("active%0d", c), active[c], m_act[c]);
        end
        check("rvalid", rvalid, m_rvalid);
        check("rdata", rdata, m_rdata);
    endtask

    task automatic cycle(input bit we, input bit re, input logic [7:0] a,
                         input logic [31:0] d, input bit sy);
        wr_en = we; rd_en = re; addr = a; wdata = d; sync = sy;
        @(posedge clk);
        model_edge(we, re, a, d, sy);
        #1;
        wr_en = 0; rd_en = 0; sync = 0;
        compare_all();
    endtask

    int exp_tog [9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    int exp_pwm [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    int exp_tri [8]  = '{0, 4, 8, 10, 6, 2, 0, 4};
    int exp_saw [5]  = '{0, 3, 6, 9, 0};
    int exp_sync [4] = '{0, 0, 3, 6};

    initial begin
        bit          r_we, r_re, r_sy;
        logic [3:0]  r_ch;
        logic [7:0]  r_a;
        logic [31:0] r_d;

        rst = 1; wr_en = 0; rd_en = 0; sync = 0; addr = 0; wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wave", wave, 0);
        check("rst_active", active, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", rvalid, 0);
        @(negedge clk);
        rst = 0;

        // Channel 0 TOGGLE len 3
        cycle(1, 0, 8'h04, 32'd3, 0);
        cycle(1, 0, 8'h00, 32'h9, 0);
        check("tog_restart", slice(0), 0);
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 8'h00, 0, 0);
            check($sformatf("tog%0d", i), slice(0), exp_tog[i]);
        end

        // Channel 1 PWM 2/3, PARAM1 -> 5 during the first high phase
        cycle(1, 0, 8'h14, 32'd2, 0);
        cycle(1, 0, 8'h18, 32'd3, 0);
        cycle(1, 0, 8'h10, 32'hA, 0);
        cycle(0, 0, 8'h00, 0, 0);
        check("pwm_high0", slice(1), 1);
        cycle(1, 0, 8'h14, 32'd5, 0);
        check("pwm_high1", slice(1), 1);
        for (int i = 0; i < 11; i++) begin
            cycle(0, 0, 8'h00, 0, 0);
            check($sformatf("pwm%0d", i), slice(1), exp_pwm[i]);
        end

        // Channel 2 TRI amp 10 step 4, STATUS read while the sample is 10
        cycle(1, 0, 8'h24, 32'd10, 0);
        cycle(1, 0, 8'h28, 32'd4, 0);
        cycle(1, 0, 8'h20, 32'hD, 0);
        check("tri_restart", slice(2), 0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, i == 4, 8'h2C, 0, 0);
            check($sformatf("tri%0d", i), slice(2), exp_tri[i]);
            if (i == 4) begin
                check("tri_rvalid", rvalid, 1);
                check("tri_status", rdata, exp_tri[3]);
            end
        end

        // Channel 3 SAW amp 10 step 3, then a global sync
        cycle(1, 0, 8'h34, 32'd10, 0);
        cycle(1, 0, 8'h38, 32'd3, 0);
        cycle(1, 0, 8'h30, 32'hE, 0);
        check("saw_restart", slice(3), 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 8'h00, 0, 0);
            check($sformatf("saw%0d", i), slice(3), exp_saw[i]);
        end
        cycle(0, 0, 8'h00, 0, 1);
        check("sync0", slice(3), exp_sync[0]);
        for (int i = 1; i < 4; i++) begin
            cycle(0, 0, 8'h00, 0, 0);
            check($sformatf("sync%0d", i), slice(3), exp_sync[i]);
        end

        // Out-of-range channel is inert and reads zero
        cycle(1, 0, 8'hF0, 32'hA, 0);
        cycle(1, 0, 8'hF4, 32'd7, 0);
        cycle(0, 1, 8'hF0, 0, 0);
        check("ch15_rvalid", rvalid, 1);
        check("ch15_rdata", rdata, 0);
        cycle(0, 1, 8'h10, 0, 0);
        check("ch1_ctrl", rdata, 32'hA);
        check("ch1_active", active[1], 1);

        // Asynchronous reset in the middle of a PWM period
        #2;
        rst = 1;
        #1;
        check("arst_wave", wave, 0);
        check("arst_active", active, 0);
        check("arst_rdata", rdata, 0);
        check("arst_rvalid", rvalid, 0);
        model_reset();
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 3000; i++) begin
            r_we = ($urandom_range(0, 2) == 0);
            r_re = ($urandom_range(0, 3) == 0);
            r_sy = ($urandom_range(0, 40) == 0);
            r_ch = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                                : 4'($urandom_range(0, 3));
            r_a  = {r_ch, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            r_d  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 15));
            cycle(r_we, r_re, r_a, r_d, r_sy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_gen_mc.md
WAVE_GEN_MC -- requirements
Module: wave_gen_mc

Interface
REQ-001 Parameter NCH, default 4, number of independent waveform channels (1..16).
REQ-002 Parameter W, default 16, output sample width per channel (1..32).
REQ-003 Port clk  in  1  single clock; all logic is on the rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port wr_en  in  1  register write strobe, one write per cycle.
REQ-006 Port rd_en  in  1  register read strobe.
REQ-007 Port addr  in  8  byte address: addr[7:4] channel, addr[3:2] register, addr[1:0] ignored.
REQ-008 Port wdata  in  32  write data.
REQ-009 Port rdata  out  32  read data.
REQ-010 Port rvalid  out  1  one-cycle pulse qualifying rdata.
REQ-011 Port sync  in  1  global phase restart pulse for all channels.
REQ-012 Port wave  out  NCH*W  channel c sample at bits [c*W+W-1 : c*W].
REQ-013 Port active  out  NCH  channel c enabled and mode not OFF.

Function
REQ-014 Register map per channel: 0 CTRL (mode[2:0], en[3]), 1 PARAM1, 2 PARAM2, 3 STATUS (read-only, zero-extended current sample).
REQ-015 Mode encodings: OFF=0, TOGGLE=1, PWM=2, PRN=3, RECT=4, TRI=5, SAW=6; code 7 is reserved and behaves as OFF.
REQ-016 Writes to channel index >= NCH, and writes to STATUS, are ignored; reads from channel index >= NCH return 0.
REQ-017 A read returns rdata, with rvalid=1, exactly one cycle after rd_en; rdata holds its value until the next read.
REQ-018 PARAM1/PARAM2 writes go to shadow registers; shadows copy to active registers at the channel period boundary, or immediately if en=0.
REQ-019 A CTRL write that changes mode or en, or a sync pulse, restarts the channel on the next cycle:
- counter, accumulator and direction are cleared
- LFSR is loaded from the PRN seed
- shadows are copied to active registers
- sample is 0.
REQ-020 When sync and a CTRL write occur in the same cycle, the write is captured and both take effect together as one restart.
REQ-021 A disabled or OFF channel outputs 0 and holds its counters cleared.
REQ-022 TOGGLE (PARAM1=len): bit 0 inverts every max(len,1) cycles; the period boundary is each inversion.
REQ-023 PWM (PARAM1=high, PARAM2=low): high for `high` cycles, then low for `low` cycles.
- high=0 gives constant 0.
- low=0 with high>0 gives constant 1.
- The period boundary is the low-to-high transition.
REQ-024 PRN (PARAM1=seed, PARAM2=taps): 32-bit Galois LFSR, one shift per cycle; output is lfsr[0].
- A seed of 0 is replaced by 1.
- If the state reaches 0, it reloads 1.
- The period boundary is every cycle.
REQ-025 RECT (PARAM1=amp, PARAM2=period): sample = amp while counter < period>>1, else 0.
- The counter wraps at period-1.
- period<2 gives 0.
REQ-026 TRI (PARAM1=amp, PARAM2=step): accumulator rises by step and saturates at amp, then falls by step and saturates at 0.
- Direction reverses when the accumulator reaches amp or 0.
- step=0 holds 0.
- The period boundary is reaching 0 on the way down.
REQ-027 SAW (PARAM1=amp, PARAM2=step): accumulator += step; if the result is >= amp, the accumulator becomes 0 and that is the period boundary.
- amp=0 or step=0 gives 0.
REQ-028 All arithmetic uses 33 bits internally, so no wrap is hidden.
REQ-029 The sample is truncated to W LSBs; single-bit modes drive bit 0 only, with upper bits 0.
REQ-030 Latency: a CTRL write in cycle n is visible in the active registers at n+1; the first new sample appears on wave at n+2.
REQ-031 wave is registered; active is registered alongside it.

Reset
REQ-032 rst asserted clears all of the following asynchronously:
- CTRL, PARAM shadow and active registers, counters, accumulators, LFSRs
- wave=0, active=0, rdata=0, rvalid=0.
REQ-033 rst deasserting mid-period resumes from the cleared state; no partial period is retained.

Structure
REQ-034 Package wave_gen_pkg holds the mode encodings, register offsets and the LFSR default seed.
REQ-035 One sub-module, wave_chan, implements a single channel (registers, shadows, generator).
REQ-036 wave_gen_mc holds address decode, the read mux and a generate loop of NCH wave_chan instances.

Verification
REQ-037 Channel 0 TOGGLE, PARAM1=3, en=1 -> wave[0] inverts every 3 cycles, starting 2 cycles after the CTRL write.
REQ-038 Channel 1 PWM high=2, low=3; PARAM1 rewritten to 5 mid-high -> current period keeps high=2; the next period has high=5.
REQ-039 Channel 2 TRI amp=10, step=4 -> samples 0,4,8,10,6,2,0,4...
REQ-040 Channel 3 SAW amp=10, step=3 -> samples 0,3,6,9,0,3...; a sync pulse mid-sequence -> next sample 0, then 3.
REQ-041 Read STATUS of channel 2 during TRI -> rvalid one cycle after rd_en, rdata equals the wave slice of that cycle.
REQ-042 Write to channel 15 with NCH=4 -> no state change; its read returns 0; rst asserted mid-PWM -> wave=0 and active=0 immediately.
